// File: rtl/wb_arb2_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb2_if
// Description : Bundle of the two Wishbone master ports and the single slave
//               port served by wb_arb2. The "slave" modport is the arbiter's
//               view (it answers the masters and drives the slave bus); the
//               "master" modport is the surrounding system's view (masters
//               plus the slave device).
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arb2_if #(
    parameter int c_DATA_WIDTH = 64
) ();

    // master 0 (TLP-to-Wishbone)
    logic                    m0_cyc_i;
    logic                    m0_stb_i;
    logic                    m0_we_i;
    logic                    m0_lock_i;
    logic [31:0]             m0_adr_i;
    logic [c_DATA_WIDTH-1:0] m0_dat_i;
    logic [7:0]              m0_sel_i;
    logic [c_DATA_WIDTH-1:0] m0_dat_o;
    logic                    m0_ack_o;
    logic                    m0_err_o;

    // master 1 (local maintenance / DMA)
    logic                    m1_cyc_i;
    logic                    m1_stb_i;
    logic                    m1_we_i;
    logic                    m1_lock_i;
    logic [31:0]             m1_adr_i;
    logic [c_DATA_WIDTH-1:0] m1_dat_i;
    logic [7:0]              m1_sel_i;
    logic [c_DATA_WIDTH-1:0] m1_dat_o;
    logic                    m1_ack_o;
    logic                    m1_err_o;

    // shared slave
    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic                    s_lock_o;
    logic [31:0]             s_adr_o;
    logic [c_DATA_WIDTH-1:0] s_dat_o;
    logic [7:0]              s_sel_o;
    logic [c_DATA_WIDTH-1:0] s_dat_i;
    logic                    s_ack_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i
    );

endinterface
`default_nettype wire

// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb2
// Description : Two-master, single-slave Wishbone arbiter for the BAR register
//               space. Round-robin grant with lock hold-off, and a watchdog
//               that aborts slave cycles that never acknowledge so a dead
//               register cannot stall the PCIe receive path.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int c_DATA_WIDTH = 64,
    parameter int TIMEOUT      = 256,   // unacked strobe cycles before abort, 0 = off
    parameter int TO_W         = 9      // 2**TO_W must exceed TIMEOUT
) (
    input  wire logic    wb_clk,
    input  wire logic    rst,
    wb_arb2_if.slave     bus,
    output logic [1:0]   gnt,
    output logic [7:0]   err_cnt
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_GNT0 = 2'd1;
    localparam logic [1:0] c_S_GNT1 = 2'd2;
    localparam logic [1:0] c_S_ERR  = 2'd3;

    localparam bit            c_WD_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] c_WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]      r_state;
    logic            r_last_gnt;    // index of the master served most recently
    logic            r_err_who;     // master whose cycle was aborted
    logic [TO_W-1:0] r_wd;
    logic [7:0]      r_err_cnt;

    logic w_busy;                   // in GNT0 or GNT1
    logic w_idx;                    // master currently steering the slave bus
    logic w_cyc;
    logic w_stb;
    logic w_lock;
    logic w_s_stb;
    logic w_wd_fire;

    // Select which master drives the slave bus: the grant holder, the aborted
    // master during ERR, otherwise the last one served so the bus stays quiet.
    always_comb begin
        w_busy = (r_state == c_S_GNT0) || (r_state == c_S_GNT1);
        case (r_state)
            c_S_GNT0: w_idx = 1'b0;
            c_S_GNT1: w_idx = 1'b1;
            c_S_ERR:  w_idx = r_err_who;
            default:  w_idx = r_last_gnt;
        endcase
    end

    assign w_cyc  = w_idx ? bus.m1_cyc_i  : bus.m0_cyc_i;
    assign w_stb  = w_idx ? bus.m1_stb_i  : bus.m0_stb_i;
    assign w_lock = w_idx ? bus.m1_lock_i : bus.m0_lock_i;

    // A strobe without cyc is not a bus cycle, so it never reaches the slave.
    assign w_s_stb = w_busy & w_cyc & w_stb;

    assign bus.s_cyc_o  = w_busy & w_cyc;
    assign bus.s_stb_o  = w_s_stb;
    assign bus.s_lock_o = w_busy & w_lock;
    assign bus.s_we_o   = w_idx ? bus.m1_we_i  : bus.m0_we_i;
    assign bus.s_adr_o  = w_idx ? bus.m1_adr_i : bus.m0_adr_i;
    assign bus.s_dat_o  = w_idx ? bus.m1_dat_i : bus.m0_dat_i;
    assign bus.s_sel_o  = w_idx ? bus.m1_sel_i : bus.m0_sel_i;

    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

    assign gnt          = {r_state == c_S_GNT1, r_state == c_S_GNT0};
    assign bus.m0_ack_o = bus.s_ack_i & gnt[0];
    assign bus.m1_ack_o = bus.s_ack_i & gnt[1];
    assign bus.m0_err_o = (r_state == c_S_ERR) & ~r_err_who;
    assign bus.m1_err_o = (r_state == c_S_ERR) &  r_err_who;
    assign err_cnt      = r_err_cnt;

    // A late ack in the last allowed cycle still wins over the abort.
    assign w_wd_fire = c_WD_EN && w_s_stb && !bus.s_ack_i && (r_wd == c_WD_LAST);

    // Grant state machine, round-robin bookkeeping, watchdog and abort counter.
    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_last_gnt <= 1'b1;
            r_err_who  <= 1'b0;
            r_wd       <= '0;
            r_err_cnt  <= 8'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_wd <= '0;
                    if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                        r_state <= r_last_gnt ? c_S_GNT0 : c_S_GNT1;
                    end else if (bus.m0_cyc_i) begin
                        r_state <= c_S_GNT0;
                    end else if (bus.m1_cyc_i) begin
                        r_state <= c_S_GNT1;
                    end
                end
                c_S_GNT0, c_S_GNT1: begin
                    if (w_wd_fire) begin
                        r_state   <= c_S_ERR;
                        r_err_who <= w_idx;
                        r_wd      <= '0;
                    end else if (!w_cyc && !w_lock) begin
                        r_state    <= c_S_IDLE;
                        r_last_gnt <= w_idx;
                        r_wd       <= '0;
                    end else if (bus.s_ack_i || !w_s_stb) begin
                        r_wd <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: begin
                    // ERR lasts one cycle and ignores lock.
                    r_state    <= c_S_IDLE;
                    r_last_gnt <= r_err_who;
                    r_wd       <= '0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
